motor_tick_prescaler: RTL and testbench

Programmable prescaler that runs on the muxed clock leaving the clock-select stage (`clock_out_a`) and turns it into a one-cycle tick enable, a half-rate toggle and a wrapping tick count for the motor PWM/step logic. The divisor is double-buffered. A new value is captured into a shadow register through a load/ack handshake, and it takes effect only at a period boundary, so switching rate never produces a short or long period.

---
 rtl/motor_tick_prescaler.sv | 70 +++++++
 tb/tb_motor_tick_prescaler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/motor_tick_prescaler.sv
// Programmable tick prescaler with a double-buffered divisor; tick period is D+1 clocks, all outputs registered.
// No backpressure: loads are accepted every cycle (acked next cycle) and take effect at a period boundary or while disabled.
module motor_tick_prescaler #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     div_value,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 pending,
    output logic                 tick,
    output logic                 tick_toggle,
    output logic [CNT_WIDTH-1:0] tick_count
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] shadow_div;
    logic [WIDTH-1:0] reload;
    logic             wrap;
    logic             apply;

    assign reload = pending ? shadow_div : active_div;
    assign wrap   = (cnt == '0);
    // A pending divisor is consumed on a wrap, or at any edge while held disabled.
    assign apply  = !enable || wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            active_div  <= '0;
            shadow_div  <= '0;
            pending     <= 1'b0;
            tick        <= 1'b0;
            tick_toggle <= 1'b0;
            tick_count  <= '0;
            div_ack     <= 1'b0;
        end else begin
            div_ack <= div_load;
            if (div_load) begin
                shadow_div <= div_value;
                pending    <= 1'b1;
            end else if (apply) begin
                pending    <= 1'b0;
            end

            if (enable) begin
                if (wrap) begin
                    tick        <= 1'b1;
                    tick_toggle <= ~tick_toggle;
                    tick_count  <= tick_count + 1'b1;
                    cnt         <= reload;
                    active_div  <= reload;
                end else begin
                    tick <= 1'b0;
                    cnt  <= cnt - 1'b1;
                end
            end else begin
                // Disabled: abandon the partial period so re-enable starts a full one.
                tick       <= 1'b0;
                cnt        <= reload;
                active_div <= reload;
            end
        end
    end

endmodule

// File: tb/tb_motor_tick_prescaler.sv
// Directed bench for motor_tick_prescaler: hand-computed tick spacing, handshake and counter values.
module tb_motor_tick_prescaler;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_value;
    logic        div_load;
    logic        div_ack;
    logic        pending;
    logic        tick;
    logic        tick_toggle;
    logic [7:0]  tick_count;

    int total = 0;
    int bad   = 0;

    motor_tick_prescaler #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .div_value   (div_value),
        .div_load    (div_load),
        .div_ack     (div_ack),
        .pending     (pending),
        .tick        (tick),
        .tick_toggle (tick_toggle),
        .tick_count  (tick_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expect tick low for n-1 edges and high on the n-th.
    task automatic expect_period(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            step();
            chk(tag, {31'd0, tick}, (i == n) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        div_value = 16'd0;
        div_load  = 1'b0;
        #2;
        step();
        step();
        chk("rst_tick",    {31'd0, tick},        32'd0);
        chk("rst_toggle",  {31'd0, tick_toggle}, 32'd0);
        chk("rst_count",   {24'd0, tick_count},  32'd0);
        chk("rst_pending", {31'd0, pending},     32'd0);
        chk("rst_ack",     {31'd0, div_ack},     32'd0);

        // Defaults: D=0 ticks every cycle.
        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("d0_tick",   {31'd0, tick},        32'd1);
            chk("d0_toggle", {31'd0, tick_toggle}, k % 2);
            chk("d0_count",  {24'd0, tick_count},  k);
        end
        for (int k = 6; k <= 255; k++) step();
        chk("d0_count_ff",   {24'd0, tick_count}, 32'hFF);
        step();
        chk("d0_count_wrap", {24'd0, tick_count}, 32'h00);

        // Load D=4 while disabled.
        enable    = 1'b0;
        div_load  = 1'b1;
        div_value = 16'd4;
        step();
        div_load = 1'b0;
        chk("dis_ack1",  {31'd0, div_ack}, 32'd1);
        chk("dis_pend1", {31'd0, pending}, 32'd1);
        chk("dis_tick",  {31'd0, tick},    32'd0);
        step();
        chk("dis_ack0",  {31'd0, div_ack}, 32'd0);
        chk("dis_pend0", {31'd0, pending}, 32'd0);
        enable = 1'b1;
        expect_period(5, "d4_first");
        expect_period(5, "d4_second");
        chk("d4_count", {24'd0, tick_count}, 32'd2);

        // Load D=9 two cycles before the wrap.
        step();
        step();
        div_load  = 1'b1;
        div_value = 16'd9;
        step();
        div_load = 1'b0;
        chk("chg_ack",  {31'd0, div_ack}, 32'd1);
        chk("chg_pend", {31'd0, pending}, 32'd1);
        chk("chg_tick", {31'd0, tick},    32'd0);
        step();
        chk("chg_tick_b", {31'd0, tick},    32'd0);
        chk("chg_pend_b", {31'd0, pending}, 32'd1);
        step();
        chk("chg_wrap_tick", {31'd0, tick},    32'd1);
        chk("chg_wrap_pend", {31'd0, pending}, 32'd0);
        expect_period(10, "d9_period");

        // Load on the wrap edge: back to D=4 first, then load D=2 where cnt=0.
        enable    = 1'b0;
        div_load  = 1'b1;
        div_value = 16'd4;
        step();
        div_load = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_pre", {31'd0, tick}, 32'd0);
        end
        div_load  = 1'b1;
        div_value = 16'd2;
        step();
        div_load = 1'b0;
        chk("wrap_tick", {31'd0, tick},    32'd1);
        chk("wrap_pend", {31'd0, pending}, 32'd1);
        chk("wrap_ack",  {31'd0, div_ack}, 32'd1);
        expect_period(5, "wrap_old");
        chk("wrap_pend_clr", {31'd0, pending}, 32'd0);
        expect_period(3, "d2_a");
        expect_period(3, "d2_b");

        // Back-to-back loads 7, 8, 6 while disabled.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            div_load  = 1'b1;
            div_value = (i == 0) ? 16'd7 : (i == 1) ? 16'd8 : 16'd6;
            step();
            chk("b2b_ack", {31'd0, div_ack}, 32'd1);
        end
        div_load = 1'b0;
        step();
        chk("b2b_ack0",  {31'd0, div_ack}, 32'd0);
        chk("b2b_pend0", {31'd0, pending}, 32'd0);
        enable = 1'b1;
        expect_period(7, "d6_a");
        expect_period(7, "d6_b");

        // Enable drop mid-period restarts a full period.
        step();
        step();
        step();
        enable = 1'b0;
        step();
        chk("drop_tick", {31'd0, tick}, 32'd0);
        enable = 1'b1;
        expect_period(7, "drop_fresh");

        // Reset mid-period with pending set and a simultaneous load.
        div_load  = 1'b1;
        div_value = 16'd9;
        step();
        chk("pre_rst_pend", {31'd0, pending}, 32'd1);
        reset     = 1'b1;
        div_value = 16'd5;
        step();
        chk("mid_rst_tick",   {31'd0, tick},        32'd0);
        chk("mid_rst_toggle", {31'd0, tick_toggle}, 32'd0);
        chk("mid_rst_count",  {24'd0, tick_count},  32'd0);
        chk("mid_rst_pend",   {31'd0, pending},     32'd0);
        chk("mid_rst_ack",    {31'd0, div_ack},     32'd0);
        reset    = 1'b0;
        div_load = 1'b0;
        expect_period(1, "post_rst_d0_a");
        expect_period(1, "post_rst_d0_b");
        chk("post_rst_count", {24'd0, tick_count}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
